// File: rtl/alu_issuer.sv
// alu_issuer: buffers ALU commands in a small FIFO and issues them one at a time
// over the cs/rdy handshake. Optional stuck-operation watchdog: define ALU_ISSUER_WDOG_EN.
//
// Handshakes: a command moves when cmd_valid && cmd_ready on a rising edge; a result
// is held (res_valid=1, fields constant) until res_valid && res_ready on a rising edge.
// ALU side: alu_cs high until the ALU drops alu_rdy, result taken when alu_rdy rises.

module alu_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_cs,
  input  logic [15:0] alu_out,
  input  logic        alu_cout,
  input  logic        alu_rdy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_cout,
  output logic [2:0]  res_op,
  output logic        res_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0]  OP_UNSUPPORTED = 3'd3;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_issuer: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("alu_issuer: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  cmd_t          head;
  logic          fifo_empty, fifo_full, push, pop;

  state_e        state_q, state_d;
  logic [15:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          alu_cs_q, alu_cs_d;
  logic          res_valid_q, res_valid_d;
  logic [15:0]   res_data_q, res_data_d;
  logic          res_cout_q, res_cout_d;
  logic [2:0]    res_op_q, res_op_d;
  logic          res_err_q, res_err_d;

`ifdef ALU_ISSUER_WDOG_EN
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);
  logic [WW-1:0] wdog_q, wdog_d;
`endif

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign head       = mem_q[rd_ptr_q];
  assign push       = cmd_valid && !fifo_full;

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_cs_d    = alu_cs_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_cout_d  = res_cout_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && alu_rdy) begin
          pop      = 1'b1;
          alu_a_d  = head.a;
          alu_b_d  = head.b;
          alu_op_d = head.op;
          // The ALU has no op 3: answer with an error locally, never touching cs.
          if (head.op == OP_UNSUPPORTED) begin
            res_data_d  = '0;
            res_cout_d  = 1'b0;
            res_op_d    = head.op;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            alu_cs_d = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!alu_rdy) begin
          alu_cs_d = 1'b0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (alu_rdy) begin
          res_data_d  = alu_out;
          res_cout_d  = alu_cout;
          res_op_d    = alu_op_q;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef ALU_ISSUER_WDOG_EN
    wdog_d = wdog_q;
    if (pop) begin
      wdog_d = '0;
    end else if (state_q == S_ISSUE || state_q == S_BUSY) begin
      wdog_d = wdog_q + WW'(1);
      // A real handshake on the same edge wins over the timeout.
      if (state_d == state_q && wdog_d == WD_LIMIT) begin
        alu_cs_d    = 1'b0;
        res_data_d  = '0;
        res_cout_d  = 1'b0;
        res_op_d    = alu_op_q;
        res_err_d   = 1'b1;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_cs_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cout_q  <= 1'b0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
`ifdef ALU_ISSUER_WDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_cs_q    <= alu_cs_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cout_q  <= res_cout_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
`ifdef ALU_ISSUER_WDOG_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign cmd_ready = !fifo_full;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_cs    = alu_cs_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed + light random bench for alu_issuer with a behavioural ALU on the far side.
// Expected results are queued at push time and compared when the issuer returns them.

module tb_alu_issuer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_cs;
  logic [15:0] alu_out;
  logic        alu_cout;
  logic        alu_rdy;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_cout;
  logic [2:0]  res_op;
  logic        res_err;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [20:0] exp_q[$];
  logic [20:0] last_res;
  int          checks = 0;
  int          errors = 0;
  int          cs_total = 0;

  // Behavioural ALU controls
  logic        alu_hold = 1'b0;
  logic        alu_dead = 1'b0;
  int          alu_lat  = 3;
  logic [16:0] model_r;

  alu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cs(alu_cs),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_rdy(alu_rdy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout), .res_op(res_op), .res_err(res_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  always @(posedge clk) if (alu_cs) cs_total <= cs_total + 1;

  function automatic logic [16:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
    logic [31:0] p;
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: begin p = a * b; return {|p[31:16], p[15:0]}; end
      3'd4: return {1'b0, a & b};
      3'd5: return {1'b0, a | b};
      3'd6: return {1'b0, a ^ b};
      3'd7: return {1'b0, ~a};
      default: return 17'h0;
    endcase
  endfunction

  // ALU: drops rdy one cycle after it sees cs, raises it alu_lat cycles later with the result.
  initial begin
    alu_rdy  = 1'b1;
    alu_out  = '0;
    alu_cout = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (alu_hold) begin
        alu_rdy = 1'b0;
      end else if (alu_cs && alu_rdy) begin
        model_r = alu_model(alu_a, alu_b, alu_op);
        alu_rdy = 1'b0;
        repeat (alu_lat) @(posedge clk);
        #1;
        alu_out  = model_r[15:0];
        alu_cout = model_r[16];
        if (!alu_dead) alu_rdy = 1'b1;
      end else if (!alu_dead) begin
        alu_rdy = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one command, accepted on the next rising edge where cmd_ready is high
  task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    int n;
    logic [16:0] r;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (op == 3'd3) begin
      exp_q.push_back({1'b1, 3'd3, 1'b0, 16'h0000});
    end else begin
      r = alu_model(a, b, op);
      exp_q.push_back({1'b0, op, r[16], r[15:0]});
    end
  endtask

  // scoreboard: wait for a result, compare against the queue head, optionally stall, then accept
  task automatic collect(input string tag, input int hold);
    int n;
    logic [20:0] got, exp;
    logic stable;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    got = {res_err, res_op, res_cout, res_data};
    last_res = got;
    check({tag, "_qnonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 21'h0;
    check(tag, {11'd0, got}, {11'd0, exp});
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!res_valid || {res_err, res_op, res_cout, res_data} !== got) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, {31'd0, stable}, 32'd1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_release"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    int n, snap, op_r, seen;

    // reset
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_outputs", {27'd0, alu_cs, res_valid, busy, dbg_state}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single add
    snap = cs_total;
    push_cmd(16'h0003, 16'h0005, 3'd0);
    @(posedge clk); #1;
    check("add_cs_after_pop", {31'd0, alu_cs}, 32'd1);
    check("add_operands", {alu_op, alu_a, alu_b[12:0]}, {3'd0, 16'h0003, 13'h0005});
    collect("add", 0);
    check("add_value", {11'd0, last_res}, {11'd0, 1'b0, 3'd0, 1'b0, 16'h0008});
    check("add_cs_cycles", cs_total - snap, 32'd1);

    // subtract with borrow, result held while res_ready low
    push_cmd(16'h0001, 16'h0002, 3'd1);
    collect("sub", 5);
    check("sub_value", {11'd0, last_res}, {11'd0, 1'b0, 3'd1, 1'b1, 16'hFFFF});

    // FIFO fill with the ALU stalled
    @(negedge clk);
    alu_hold = 1'b1;
    repeat (2) @(negedge clk);
    push_cmd(16'h0010, 16'h0010, 3'd2);
    push_cmd(16'h1234, 16'h0F0F, 3'd4);
    push_cmd(16'hFFFF, 16'h0001, 3'd0);
    push_cmd(16'hAAAA, 16'h5555, 3'd6);
    check("fill_full", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = 16'h00F0;
    cmd_b = 16'h0F00;
    cmd_op = 3'd5;
    repeat (3) @(negedge clk);
    check("fill_5th_held", {29'd0, cmd_ready, dbg_state}, {29'd0, 1'b0, 2'd0});
    check("fill_busy", {31'd0, busy}, 32'd1);
    cmd_valid = 1'b0;
    alu_hold = 1'b0;
    collect("fill0", 0);
    check("fill_mul_value", {11'd0, last_res}, {11'd0, 1'b0, 3'd2, 1'b0, 16'h0100});
    push_cmd(16'h00F0, 16'h0F00, 3'd5);
    collect("fill1", 1);
    collect("fill2", 0);
    collect("fill3", 2);
    collect("fill4", 0);

    // unsupported op 3
    snap = cs_total;
    push_cmd(16'h0007, 16'h0009, 3'd3);
    @(posedge clk); #1;
    check("op3_quick", {12'd0, res_valid, res_err, alu_cs, res_data}, {12'd0, 1'b1, 1'b1, 1'b0, 16'h0});
    collect("op3", 0);
    check("op3_no_cs", cs_total - snap, 32'd0);

    // random commands, random latency and consumer stall
    for (int i = 0; i < 6; i++) begin
      op_r = $urandom_range(0, 6);
      if (op_r >= 3) op_r++;
      alu_lat = $urandom_range(1, 5);
      push_cmd(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 3'(op_r));
      collect("rand", $urandom_range(0, 3));
    end
    alu_lat = 3;

`ifdef ALU_ISSUER_WDOG_EN
    // watchdog: ALU never raises rdy again
    alu_dead = 1'b1;
    push_cmd(16'h0011, 16'h0022, 3'd0);
    void'(exp_q.pop_back());
    exp_q.push_back({1'b1, 3'd0, 1'b0, 16'h0000});
    @(posedge clk);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("wdog_not_yet", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    check("wdog_fire", {29'd0, res_valid, res_err, alu_cs}, {29'd0, 3'b110});
    alu_dead = 1'b0;
    collect("wdog", 0);
    push_cmd(16'h0100, 16'h0001, 3'd0);
    collect("wdog_recover", 0);
`endif

    // asynchronous reset while the ALU is busy
    alu_lat = 10;
    push_cmd(16'h4000, 16'h4000, 3'd0);
    push_cmd(16'h0001, 16'h0001, 3'd0);
    n = 0;
    while (dbg_state != 2'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_reached_busy", {30'd0, dbg_state}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_outputs", {28'd0, alu_cs, res_valid, busy, cmd_ready}, 32'd1);
    check("rstmid_state", {30'd0, dbg_state}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid || alu_cs || busy) seen++;
    end
    check("rstmid_no_stale", seen, 32'd0);
    alu_lat = 3;
    push_cmd(16'h0002, 16'h0003, 3'd2);
    collect("post_reset", 0);
    check("post_reset_qempty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
